fwd_mux_hold: RTL and testbench

Parametrised N-way operand-forwarding select with a built-in pipeline register and stall-hold capture. It sits at the ID/EX boundary of the 5-stage core. It selects one of N forwarding sources (register file, EX/MEM, MEM/WB, …) and registers the selected value into the next stage. On the first cycle of a stall it latches the forwarded operand, so the value survives after its source has moved down the pipeline. Flush clears the stage.

---
 rtl/fwd_mux_hold.sv | 85 ++++++++
 tb/tb_fwd_mux_hold.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_mux_hold.sv
`timescale 1ns/1ps
// fwd_mux_hold: N-way operand-forwarding select at the ID/EX boundary.
// The selected source is registered into q every cycle. On stall entry
// the selected operand is captured so it survives after its producer
// has moved down the pipeline. Flush turns the stage into a bubble.
module fwd_mux_hold #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SW-1:0]      s,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic [WIDTH-1:0]   q,
    output logic               hold_valid
);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_held;
    logic [WIDTH-1:0] w_sel;

    // Binary-select one source; codes beyond N-1 fall back to source 0.
    always_comb begin
        w_sel = d[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (s == SW'(k)) begin
                w_sel = d[k*WIDTH +: WIDTH];
            end
        end
    end

    // While holding, the captured operand replaces the live mux output.
    always_comb begin
        y = (r_state == ST_HOLD) ? r_held : w_sel;
    end

    assign q          = r_q;
    assign hold_valid = (r_state == ST_HOLD);

    // Stage register and stall-hold FSM; flush beats stall beats advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_PASS;
            r_q     <= '0;
            r_held  <= '0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (flush) begin
                        r_q <= '0;
                    end else if (stall) begin
                        r_held  <= w_sel;
                        r_state <= ST_HOLD;
                    end else begin
                        r_q <= w_sel;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        r_q     <= '0;
                        r_held  <= '0;
                        r_state <= ST_PASS;
                    end else if (!stall) begin
                        r_q     <= r_held;
                        r_state <= ST_PASS;
                    end
                end
                default: begin
                    r_state <= ST_PASS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_mux_hold.sv
`timescale 1ns/1ps
// Bench for fwd_mux_hold: a 4-source and a 3-source instance share the
// same stimulus and are compared against a behavioural reference.
module tb_fwd_mux_hold;

    localparam int W = 32;

    logic          clk;
    logic          resetn;
    logic [W-1:0]  dsrc [4];
    logic [1:0]    s;
    logic          stall;
    logic          flush;

    logic [4*W-1:0] d4;
    logic [3*W-1:0] d3;
    logic [W-1:0]   y4, q4, y3, q3;
    logic           hv4, hv3;

    int n_checks;
    int n_fail;

    // Reference state per instance: 0 -> N=4, 1 -> N=3
    bit          m_hold [2];
    logic [W-1:0] m_held [2];
    logic [W-1:0] m_q    [2];

    assign d4 = {dsrc[3], dsrc[2], dsrc[1], dsrc[0]};
    assign d3 = {dsrc[2], dsrc[1], dsrc[0]};

    fwd_mux_hold #(.WIDTH(W), .N(4)) dut4 (
        .clk(clk), .resetn(resetn), .d(d4), .s(s), .stall(stall),
        .flush(flush), .y(y4), .q(q4), .hold_valid(hv4)
    );

    fwd_mux_hold #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .resetn(resetn), .d(d3), .s(s), .stall(stall),
        .flush(flush), .y(y3), .q(q3), .hold_valid(hv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_sel(input int n);
        if (int'(s) < n) return dsrc[s];
        return dsrc[0];
    endfunction

    function automatic logic [W-1:0] ref_y(input int i);
        int n;
        n = (i == 0) ? 4 : 3;
        return m_hold[i] ? m_held[i] : ref_sel(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1'b0;
            m_held[i] = '0;
            m_q[i]    = '0;
        end
    endtask

    task automatic check_all();
        chk("y_n4",  y4, ref_y(0));
        chk("q_n4",  q4, m_q[0]);
        chk("hv_n4", {31'd0, hv4}, {31'd0, m_hold[0]});
        chk("y_n3",  y3, ref_y(1));
        chk("q_n3",  q3, m_q[1]);
        chk("hv_n3", {31'd0, hv3}, {31'd0, m_hold[1]});
    endtask

    // One clock: predict from the inputs seen at the edge, then compare.
    task automatic tick();
        bit          nh [2];
        logic [W-1:0] nd [2];
        logic [W-1:0] nq [2];
        logic [W-1:0] cur;
        for (int i = 0; i < 2; i++) begin
            cur   = ref_sel((i == 0) ? 4 : 3);
            nh[i] = m_hold[i];
            nd[i] = m_held[i];
            nq[i] = m_q[i];
            if (resetn) begin
                if (!m_hold[i]) begin
                    if (flush) nq[i] = '0;
                    else if (stall) begin nd[i] = cur; nh[i] = 1'b1; end
                    else nq[i] = cur;
                end else begin
                    if (flush) begin nq[i] = '0; nd[i] = '0; nh[i] = 1'b0; end
                    else if (!stall) begin nq[i] = m_held[i]; nh[i] = 1'b0; end
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = nh[i];
            m_held[i] = nd[i];
            m_q[i]    = nq[i];
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        resetn = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        s      = 2'd0;
        for (int k = 0; k < 4; k++) dsrc[k] = W'(k + 1);

        // Reset with toggling inputs: outputs cleared, y still follows select
        for (int k = 0; k < 6; k++) begin
            #3;
            s = 2'(k);
            dsrc[k % 4] = $urandom;
            #1;
            check_all();
        end
        @(negedge clk);
        resetn = 1'b1;

        // Normal select
        dsrc[0] = 32'h11; dsrc[1] = 32'h22; dsrc[2] = 32'h33; dsrc[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            tick();
        end
        chk("q_norm_last", q4, 32'h44);

        // Stall capture and release
        s = 2'd2; dsrc[2] = 32'hDEADBEEF; stall = 1'b1;
        tick();
        dsrc[2] = 32'h0; s = 2'd1;
        tick();
        tick();
        chk("y_stall", y4, 32'hDEADBEEF);
        chk("q_stall", q4, 32'h44);
        stall = 1'b0;
        tick();
        chk("q_release", q4, 32'hDEADBEEF);

        // Flush together with stall while holding
        s = 2'd0; dsrc[0] = 32'hA5A5A5A5; stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        chk("q_flush_hold", q4, 32'h0);
        chk("hv_flush_hold", {31'd0, hv4}, 32'h0);
        stall = 1'b0; flush = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        chk("q_flush_pass", q4, 32'h0);
        flush = 1'b0;

        // Out-of-range select on the 3-source instance
        s = 2'd3; dsrc[0] = 32'h7;
        #1;
        chk("y_oor", y3, 32'h7);
        tick();
        chk("q_oor", q3, 32'h7);

        // Async reset mid-HOLD
        s = 2'd0; dsrc[0] = 32'h1234; stall = 1'b1;
        tick();
        tick();
        reset_pulse();
        chk("q_rst_hold", q4, 32'h0);
        stall = 1'b0; s = 2'd0; dsrc[0] = 32'h99;
        tick();
        chk("q_after_rst", q4, 32'h99);

        // Randomized traffic, with occasional mid-cycle resets
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) dsrc[k] = $urandom;
            s     = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 9) == 0);
            tick();
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
